// File: rtl/seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit per
// clock, followed by a sign-fixup cycle. Result packs {remainder, quotient}.
module seq_divider #(
  parameter int unsigned wordSize = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [wordSize-1:0]     A,
  input  logic [wordSize-1:0]     B,
  output logic                    busy,
  output logic                    done,
  output logic                    divzero,
  output logic [2*wordSize-1:0]   C
);

  localparam int unsigned CntW = $clog2(wordSize + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [wordSize-1:0]   rem_q, rem_d;
  logic [wordSize-1:0]   quo_q, quo_d;
  logic [wordSize-1:0]   dvs_q, dvs_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  done_q, done_d;
  logic                  divzero_q, divzero_d;
  logic [2*wordSize-1:0] c_q, c_d;

  // One extra bit so a shifted remainder up to 2^W - 1 compares cleanly against the divisor.
  logic [wordSize:0]     shifted;
  logic [wordSize:0]     trial;

  always_comb begin
    shifted = {rem_q, quo_q[wordSize-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    c_d       = c_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (B == '0) begin
            c_d       = {A, {wordSize{1'b1}}};
            divzero_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            // Negation of the most-negative value wraps to 2^(W-1), exact as unsigned.
            quo_d    = A[wordSize-1] ? -A : A;
            dvs_d    = B[wordSize-1] ? -B : B;
            sign_a_d = A[wordSize-1];
            sign_b_d = B[wordSize-1];
            rem_d    = '0;
            cnt_d    = '0;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        rem_d = trial[wordSize] ? shifted[wordSize-1:0] : trial[wordSize-1:0];
        quo_d = {quo_q[wordSize-2:0], ~trial[wordSize]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(wordSize - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        c_d       = {(sign_a_q ? -rem_q : rem_q),
                     ((sign_a_q ^ sign_b_q) ? -quo_q : quo_q)};
        divzero_d = 1'b0;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      c_q       <= c_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign C       = c_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results from an arithmetic
// reference; a monitor pops and compares on every done pulse, including done timing.
module tb_seq_divider;

  localparam int W = 32;

  logic            clk;
  logic            clr;
  logic            start;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic            busy;
  logic            done;
  logic            divzero;
  logic [2*W-1:0]  C;

  typedef struct {
    logic [2*W-1:0] c;
    logic           dz;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.wordSize(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .C       (C)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Truncating signed division done in 64-bit so most-negative / -1 cannot overflow.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb_;
    longint q;
    longint r;
    if (b == '0) return {a, {W{1'b1}}};
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    q   = sa / sb_;
    r   = sa % sb_;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
    exp_t e;
    e.c   = ref_div(a, b);
    e.dz  = (b == '0);
    e.cyc = (b == '0) ? c0 + 1 : c0 + W + 2;
    return e;
  endfunction

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_C", C, e.c);
        chk("divzero", divzero, e.dz);
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      chk("missing_done", 0, 1);
      void'(sb.pop_front());
    end
  end

  // Called at a negedge; scribbles on inputs while busy, then issues one request.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int guard = 0;
    while (busy && guard < 200) begin
      A     = $urandom;
      B     = $urandom;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    if (busy) chk("issue_wait_timeout", 1, 0);
    start = 1'b1;
    A     = a;
    B     = b;
    if (track) sb.push_back(mk_exp(a, b, cyc));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, (b != '0));
    A = $urandom;
    B = $urandom;
  endtask

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    clr   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_divzero", divzero, 0);
    chk("reset_C", C, 0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    issue(32'hFFFF_FFF0, 32'd2, 1'b1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'd5, 32'd0, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'd0, 32'd9, 1'b1);

    // Abort mid-run: no done, outputs cleared at once.
    issue(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_divzero", divzero, 0);
    chk("clr_C", C, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7, 1'b1);

    // Start held high with changed operands: second request taken in the done cycle.
    while (busy) @(negedge clk);
    n     = cyc;
    start = 1'b1;
    A     = 32'd100;
    B     = 32'd7;
    sb.push_back(mk_exp(32'd100, 32'd7, n));
    sb.push_back(mk_exp(32'd9, 32'd3, n + W + 2));
    @(negedge clk);
    A = 32'd9;
    B = 32'd3;
    repeat (W + 2) @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 15));
        4:       rb = -32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      issue(ra, rb, 1'b1);
    end

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter wordSize, default 32, operand width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request pulse/level; sampled only when busy=0.
REQ-005 The block SHALL have port A  input  wordSize  dividend, signed two's complement.
REQ-006 The block SHALL have port B  input  wordSize  divisor, signed two's complement.
REQ-007 The block SHALL have port busy  output  1  high while a division is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse, C/divzero valid.
REQ-009 The block SHALL have port divzero  output  1  last result was a divide-by-zero.
REQ-010 The block SHALL have port C  output  2*wordSize  result {remainder[2W-1:W], quotient[W-1:0]}, same packing as the ALU C bus it feeds (HI=remainder, LO=quotient).

Function
REQ-011 The FSM SHALL have states IDLE, RUN, FIX; busy=1 exactly in RUN and FIX.
REQ-012 IDLE, start=1, B!=0: on the edge, capture |A|, |B| as wordSize-bit unsigned magnitudes plus sign(A), sign(B); clear partial remainder; iteration counter=0; go to RUN.
REQ-013 RUN: one restoring-division step per edge (shift remainder/quotient left, trial subtract, restore on borrow, set quotient bit); after wordSize steps go to FIX.
REQ-014 FIX: on the edge, quotient negated if sign(A)^sign(B), remainder takes sign of A (negated if A<0); C loaded, divzero=0, done=1, go to IDLE.
REQ-015 Latency SHALL be exactly wordSize+2 edges from the edge sampling start to the edge asserting done (34 for W=32).
REQ-016 done SHALL be high for exactly one cycle; the FSM is IDLE in that cycle, so a start in the done cycle SHALL be accepted (back-to-back issue).
REQ-017 IDLE, start=1, B==0: on the next edge C={A, all ones}, divzero=1, done=1, FSM stays IDLE (latency 1).
REQ-018 start while busy=1 SHALL be ignored; A/B changes while busy SHALL NOT affect the result.
REQ-019 C and divzero SHALL hold their values from done until the next done or clr.
REQ-020 Most-negative / -1 SHALL yield quotient = most-negative (wrap), remainder 0, divzero=0.
REQ-021 |most-negative| SHALL be represented as unsigned 2^(W-1) without overflow.

Reset
REQ-022 clr=1 SHALL immediately force FSM=IDLE, counter=0, busy=0, done=0, divzero=0, C=0, independent of clk.
REQ-023 clr mid-RUN/FIX SHALL abort silently: no done pulse, no C update.
REQ-024 After clr deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-025 A=-16, B=2, start 1 cycle -> busy for 33 cycles, done at edge 34, C=0x00000000_FFFFFFF8, divzero=0.
REQ-026 A=7, B=-2 -> C=0x00000001_FFFFFFFD; A=-7, B=2 -> C=0xFFFFFFFF_FFFFFFFD.
REQ-027 A=5, B=0 -> done 1 edge later, divzero=1, C=0x00000005_FFFFFFFF, busy never high.
REQ-028 A=0x80000000, B=0xFFFFFFFF -> C=0x00000000_80000000, divzero=0.
REQ-029 Start 100/7, assert clr at cycle 10 -> busy/C/done=0 immediately, no done; then start 100/7 -> C=0x00000002_0000000E after 34 edges.
REQ-030 Start 100/7, hold start high with A/B changed to 9/3 throughout -> first result C=0x00000002_0000000E; second start accepted in done cycle -> C=0x00000000_00000003 34 edges later.
